// File: rtl/uart_sched_pkg.sv
// Shared types and constants for the UART transmit scheduler and its FIFO.
package uart_sched_pkg;

    localparam int unsigned DATA_W           = 8;
    localparam int unsigned FIFO_DEPTH       = 8;
    localparam int unsigned BUSY_TIMEOUT_DEF = 16;

    typedef logic [DATA_W-1:0] byte_t;

    // Occupancy counter must hold 0..depth inclusive.
    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

    localparam int unsigned CNT_W = cnt_width(FIFO_DEPTH);

    localparam logic REQ_CPU  = 1'b0;
    localparam logic REQ_ECHO = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        WAIT_BUSY,
        WAIT_DONE
    } state_t;

    typedef struct packed {
        logic  req;
        byte_t data;
    } tx_req_t;

endpackage

// File: rtl/uart_tx_scheduler_if.sv
// Requester, transmitter and status signals of the UART transmit scheduler.
interface uart_tx_scheduler_if #(
    parameter int unsigned CW = uart_sched_pkg::CNT_W
);
    import uart_sched_pkg::*;

    logic          cpu_req;
    byte_t         cpu_data;
    logic          cpu_ack;
    logic          echo_req;
    byte_t         echo_data;
    logic          echo_ack;
    logic          tx_en;
    byte_t         tx_data;
    logic          tx_status;
    logic [CW-1:0] fifo_count;
    logic          busy;
    logic          timeout_err;

    // Scheduler side.
    modport slave (
        input  cpu_req, cpu_data, echo_req, echo_data, tx_status,
        output cpu_ack, echo_ack, tx_en, tx_data, fifo_count, busy, timeout_err
    );

    // Requesters / transmitter side.
    modport master (
        output cpu_req, cpu_data, echo_req, echo_data, tx_status,
        input  cpu_ack, echo_ack, tx_en, tx_data, fifo_count, busy, timeout_err
    );

endinterface

// File: rtl/uart_tx_scheduler_fifo.sv
// Synchronous byte FIFO with a registered head entry (uart_tx_fifo).
module uart_tx_fifo
    import uart_sched_pkg::*;
#(
    parameter int unsigned DEPTH = FIFO_DEPTH
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  byte_t                  wdata,
    input  logic                   pop,
    output byte_t                  head,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int unsigned AW = $clog2(DEPTH);

    byte_t         mem [DEPTH];
    logic [AW-1:0] wp;
    logic [AW-1:0] rp;
    logic [AW-1:0] rp_n;
    logic [AW:0]   cnt;
    logic          do_push;
    logic          do_pop;

    assign full    = (cnt == (AW+1)'(DEPTH));
    assign empty   = (cnt == '0);
    assign count   = cnt;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rp_n    = do_pop ? AW'(rp + 1'b1) : rp;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wp   <= '0;
            rp   <= '0;
            cnt  <= '0;
            head <= '0;
        end else begin
            if (do_push) wp <= AW'(wp + 1'b1);
            rp <= rp_n;
            case ({do_push, do_pop})
                2'b10:   cnt <= (AW+1)'(cnt + 1'b1);
                2'b01:   cnt <= (AW+1)'(cnt - 1'b1);
                default: cnt <= cnt;
            endcase
            // Bypass the write when it lands in the slot that becomes the head.
            if (do_push && ((cnt == '0) || ((cnt == (AW+1)'(1)) && do_pop)))
                head <= wdata;
            else
                head <= mem[rp_n];
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wp] <= wdata;
    end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one UART transmitter between the CPU and the RX-echo path via a FIFO and drain FSM.
// Define UART_TX_SCHED_ECHO_EN to enable the echo requester and round-robin arbitration.
module uart_tx_scheduler
    import uart_sched_pkg::*;
#(
    parameter int unsigned DEPTH        = FIFO_DEPTH,
    parameter int unsigned BUSY_TIMEOUT = BUSY_TIMEOUT_DEF
) (
    input  logic                clk,
    input  logic                reset,
    uart_tx_scheduler_if.slave  io
);
    localparam int unsigned CW = cnt_width(DEPTH);
    localparam int unsigned TW = $clog2(BUSY_TIMEOUT);

    logic          grant_cpu;
    logic          grant_echo;
    logic          push;
    byte_t         wdata;
    logic          pop;
    byte_t         head;
    logic          full;
    logic          empty;
    logic [CW-1:0] count;
    logic          cpu_ack_q;
    logic          echo_ack_q;
    tx_req_t       cpu_in;

    assign cpu_in = '{req: io.cpu_req, data: io.cpu_data};

`ifdef UART_TX_SCHED_ECHO_EN
    tx_req_t echo_in;
    logic    rr;
    logic    rr_n;

    assign echo_in = '{req: io.echo_req, data: io.echo_data};

    // Contested grants go to the rr requester, then rr points at the loser.
    always_comb begin
        grant_cpu  = 1'b0;
        grant_echo = 1'b0;
        rr_n       = rr;
        if (!full) begin
            if (cpu_in.req && echo_in.req) begin
                if (rr == REQ_CPU) begin
                    grant_cpu = 1'b1;
                    rr_n      = REQ_ECHO;
                end else begin
                    grant_echo = 1'b1;
                    rr_n       = REQ_CPU;
                end
            end else begin
                grant_cpu  = cpu_in.req;
                grant_echo = echo_in.req;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) rr <= REQ_CPU;
        else        rr <= rr_n;
    end

    assign wdata = grant_echo ? echo_in.data : cpu_in.data;
`else
    logic unused_echo;

    assign unused_echo = ^{io.echo_req, io.echo_data};
    assign grant_cpu   = cpu_in.req && !full;
    assign grant_echo  = 1'b0;
    assign wdata       = cpu_in.data;
`endif

    assign push = grant_cpu || grant_echo;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cpu_ack_q  <= 1'b0;
            echo_ack_q <= 1'b0;
        end else begin
            cpu_ack_q  <= grant_cpu;
            echo_ack_q <= grant_echo;
        end
    end

    uart_tx_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .wdata (wdata),
        .pop   (pop),
        .head  (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    state_t        state;
    state_t        state_n;
    logic          tx_en_q;
    logic          tx_en_n;
    byte_t         tx_data_q;
    byte_t         tx_data_n;
    logic          terr_q;
    logic          terr_n;
    logic [TW-1:0] tcnt;
    logic [TW-1:0] tcnt_n;

    // Drain FSM: one byte per transmitter busy/idle cycle, bounded wait for busy.
    always_comb begin
        state_n   = state;
        tx_en_n   = 1'b0;
        tx_data_n = tx_data_q;
        terr_n    = terr_q;
        tcnt_n    = tcnt;
        pop       = 1'b0;
        unique case (state)
            IDLE: begin
                if (!empty && io.tx_status) state_n = LOAD;
            end
            LOAD: begin
                tx_en_n   = 1'b1;
                tx_data_n = head;
                tcnt_n    = '0;
                state_n   = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (!io.tx_status) begin
                    state_n = WAIT_DONE;
                end else if (tcnt == TW'(BUSY_TIMEOUT - 1)) begin
                    terr_n  = 1'b1;
                    pop     = 1'b1;
                    state_n = IDLE;
                end else begin
                    tcnt_n = TW'(tcnt + 1'b1);
                end
            end
            WAIT_DONE: begin
                if (io.tx_status) begin
                    pop     = 1'b1;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            tx_en_q   <= 1'b0;
            tx_data_q <= '0;
            terr_q    <= 1'b0;
            tcnt      <= '0;
        end else begin
            state     <= state_n;
            tx_en_q   <= tx_en_n;
            tx_data_q <= tx_data_n;
            terr_q    <= terr_n;
            tcnt      <= tcnt_n;
        end
    end

    assign io.cpu_ack     = cpu_ack_q;
    assign io.echo_ack    = echo_ack_q;
    assign io.tx_en       = tx_en_q;
    assign io.tx_data     = tx_data_q;
    assign io.timeout_err = terr_q;
    assign io.fifo_count  = count;
    assign io.busy        = !empty || (state != IDLE);

endmodule
